// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C target exposing an 8-bit register file with auto-incrementing pointer
// Ports: i_clk/i_rst (async, active high), i_scl/io_sda bus pins (SDA open drain),
//        i_host_sel/o_host_rdata host read port, o_wr_stb/o_wr_addr/o_wr_data write
//        notification, o_busy high while this target is addressed.
// Option: define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA.
module i2c_reg_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         NUM_REGS    = 16,
    parameter int         PTR_W       = 4,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_scl,
    inout  wire              io_sda,
    input  logic [PTR_W-1:0] i_host_sel,
    output logic [7:0]       o_host_rdata,
    output logic             o_wr_stb,
    output logic [PTR_W-1:0] o_wr_addr,
    output logic [7:0]       o_wr_data,
    output logic             o_busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_s, sda_s, scl_p_q, sda_p_q;
    logic                   rise, fall, start, stop;
    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [7:0]             shift_q, shift_d, byte_in, rd;
    logic [PTR_W-1:0]       ptr_q, ptr_d, waddr_q, waddr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   oe_q, oe_d, busy_q, busy_d, rw_q, rw_d;
    logic                   wpend_q, wpend_d, stb_q, stb_d;
    logic [7:0]             regs_q [NUM_REGS];
    logic [7:0]             regs_d [NUM_REGS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], io_sda};
            scl_p_q    <= scl_s;
            sda_p_q    <= sda_s;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [2:0] scl_h_q, sda_h_q;

    function automatic logic maj3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_h_q <= '1;
            sda_h_q <= '1;
        end else begin
            scl_h_q <= {scl_h_q[1:0], scl_sync_q[SYNC_STAGES-1]};
            sda_h_q <= {sda_h_q[1:0], sda_sync_q[SYNC_STAGES-1]};
        end
    end

    assign scl_s = maj3(scl_h_q);
    assign sda_s = maj3(sda_h_q);
`else
    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

    assign rise    = scl_s & ~scl_p_q;
    assign fall    = ~scl_s & scl_p_q;
    assign start   = scl_s & scl_p_q & sda_p_q & ~sda_s;
    assign stop    = scl_s & scl_p_q & ~sda_p_q & sda_s;
    assign byte_in = {shift_q[6:0], sda_s};
    assign rd      = regs_q[ptr_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ptr_d   = ptr_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        rw_d    = rw_q;
        wpend_d = 1'b0;
        stb_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        regs_d  = regs_q;
        // Commit of a received data byte, one cycle after its last bit.
        if (wpend_q) begin
            regs_d[ptr_q] = shift_q;
            stb_d         = 1'b1;
            waddr_d       = ptr_q;
            wdata_d       = shift_q;
            ptr_d         = ptr_q + PTR_W'(1);
        end
        if (start) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    oe_d   = 1'b0;
                    busy_d = 1'b0;
                end
                ADDR, PTR, WDATA: if (rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        if (state_q == ADDR) begin
                            busy_d  = byte_in[7:1] == TARGET_ADDR;
                            rw_d    = byte_in[0];
                            state_d = busy_d ? ADDR_ACK : WAIT_STOP;
                        end else if (state_q == PTR) begin
                            ptr_d   = byte_in[PTR_W-1:0];
                            state_d = PTR_ACK;
                        end else begin
                            wpend_d = 1'b1;
                            state_d = WDATA_ACK;
                        end
                    end
                end
                // First fall starts the ACK low; the second fall ends it.
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else if (state_q == ADDR_ACK && rw_q) begin
                        shift_d = {rd[6:0], 1'b0};
                        oe_d    = ~rd[7];
                        ptr_d   = ptr_q + PTR_W'(1);
                        cnt_d   = 4'd1;
                        state_d = RDATA;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = state_q == ADDR_ACK ? PTR : WDATA;
                    end
                end
                // cnt counts bits already placed on SDA.
                RDATA: if (fall) begin
                    if (cnt_q == 4'd8) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = RDATA_ACK;
                    end else begin
                        oe_d    = ~shift_q[7];
                        shift_d = {shift_q[6:0], 1'b0};
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                RDATA_ACK: begin
                    if (rise) begin
                        if (sda_s) state_d = WAIT_STOP;
                        else cnt_d = 4'd1;
                    end else if (fall && cnt_q[0]) begin
                        shift_d = {rd[6:0], 1'b0};
                        oe_d    = ~rd[7];
                        ptr_d   = ptr_q + PTR_W'(1);
                        cnt_d   = 4'd1;
                        state_d = RDATA;
                    end
                end
                WAIT_STOP: oe_d = 1'b0;
                default: begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            ptr_q   <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            rw_q    <= 1'b0;
            wpend_q <= 1'b0;
            stb_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            rw_q    <= rw_d;
            wpend_q <= wpend_d;
            stb_q   <= stb_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            regs_q  <= regs_d;
        end
    end

    assign io_sda       = oe_q ? 1'b0 : 1'bz;
    assign o_host_rdata = regs_q[i_host_sel];
    assign o_wr_stb     = stb_q;
    assign o_wr_addr    = waddr_q;
    assign o_wr_data    = wdata_q;
    assign o_busy       = busy_q;
endmodule
